// File: rtl/diff_gate_sched_pkg.sv
// Shared types and constants for the double-difference gate scheduler.
package diff_gate_sched_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StBurst    = 2'd1,
    StWait     = 2'd2,
    StTrigWait = 2'd3
  } state_e;

  localparam int unsigned DefaultDpLat = 2;
  // Bursts 0 and 1 after leaving idle still carry stale difference history.
  localparam int unsigned PrimeBursts  = 2;

endpackage

// File: rtl/diff_gate_sched_if.sv
// Control/status bundle between the scheduler and its user.
// Trigger signals exist only when DIFF_GATE_SCHED_TRIG_EN is defined.
interface diff_gate_sched_if #(
  parameter int unsigned Pw = 12,
  parameter int unsigned Cw = 2
) ();
  logic          enable;
  logic [Pw-1:0] period;
  logic          gate;
  logic [Cw-1:0] ch_idx;
  logic          busy;
  logic          out_gate;
  logic [Cw-1:0] out_ch;
  logic          out_primed;
`ifdef DIFF_GATE_SCHED_TRIG_EN
  logic          trig;
  logic          trig_miss;

  modport master (
    output enable, period, trig,
    input  gate, ch_idx, busy, out_gate, out_ch, out_primed, trig_miss
  );
  modport slave (
    input  enable, period, trig,
    output gate, ch_idx, busy, out_gate, out_ch, out_primed, trig_miss
  );
`else
  modport master (
    output enable, period,
    input  gate, ch_idx, busy, out_gate, out_ch, out_primed
  );
  modport slave (
    input  enable, period,
    output gate, ch_idx, busy, out_gate, out_ch, out_primed
  );
`endif
endinterface

// File: rtl/diff_gate_sched_gate_align.sv
// Depth-stage shift of {gate, channel, primed} that tracks a gated datapath's latency.
// Channel only advances with a valid gate, so the output channel holds between bursts.
module diff_gate_sched_gate_align #(
  parameter int unsigned Depth = 2,
  parameter int unsigned ChW   = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           gate_i,
  input  logic [ChW-1:0] ch_i,
  input  logic           primed_i,
  output logic           gate_o,
  output logic [ChW-1:0] ch_o,
  output logic           primed_o
);

  logic [Depth-1:0]          gate_q, gate_d;
  logic [Depth-1:0]          primed_q, primed_d;
  logic [Depth-1:0][ChW-1:0] ch_q, ch_d;

  always_comb begin
    gate_d      = gate_q;
    primed_d    = primed_q;
    ch_d        = ch_q;
    gate_d[0]   = gate_i;
    primed_d[0] = gate_i & primed_i;
    if (gate_i) ch_d[0] = ch_i;
    for (int i = 1; i < int'(Depth); i++) begin
      gate_d[i]   = gate_q[i-1];
      primed_d[i] = primed_q[i-1];
      if (gate_q[i-1]) ch_d[i] = ch_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate_q   <= '0;
      primed_q <= '0;
      ch_q     <= '0;
    end else begin
      gate_q   <= gate_d;
      primed_q <= primed_d;
      ch_q     <= ch_d;
    end
  end

  assign gate_o   = gate_q[Depth-1];
  assign ch_o     = ch_q[Depth-1];
  assign primed_o = primed_q[Depth-1];

endmodule

// File: rtl/diff_gate_sched.sv
// Gate-burst scheduler for the time-multiplexed double-difference datapath.
// Define DIFF_GATE_SCHED_TRIG_EN to make burst starts wait for an external trigger.
module diff_gate_sched
  import diff_gate_sched_pkg::*;
#(
  parameter int unsigned Nch   = 4,
  parameter int unsigned Pw    = 12,
  parameter int unsigned Cw    = 2,
  parameter int unsigned DpLat = DefaultDpLat
) (
  input logic              clk_i,
  input logic              rst_i,
  diff_gate_sched_if.slave bus
);

  localparam logic [Pw-1:0] LastCnt    = Pw'(Nch - 1);
  localparam logic [1:0]    BnumPrimed = 2'(PrimeBursts);

  state_e        state_q, state_d;
  logic [Pw-1:0] cnt_q, cnt_d;
  logic [Pw-1:0] per_q, per_d;
  logic [Pw-1:0] per_clamped;
  logic [1:0]    bnum_q, bnum_d;
  logic          gate_q, gate_d;
  logic          busy_q, busy_d;
  logic [Cw-1:0] ch_q, ch_d;
  logic          last_strobe, period_end, trig_ok, start;

  // Clamp so a burst always fits inside its own period.
  assign per_clamped = (bus.period < LastCnt) ? LastCnt : bus.period;
  assign last_strobe = (state_q == StBurst) && (cnt_q == LastCnt);
  // With the minimum period the last strobe is also the end of the period.
  assign period_end  = ((state_q == StWait) && (cnt_q == per_q)) ||
                       (last_strobe && (per_q == LastCnt));

`ifdef DIFF_GATE_SCHED_TRIG_EN
  logic trig_miss_q, trig_miss_d;

  assign trig_ok     = bus.trig;
  assign trig_miss_d = trig_miss_q |
                       (bus.trig & ~period_end &
                        ((state_q == StBurst) | (state_q == StWait)));

  always_ff @(posedge clk_i) begin
    if (rst_i) trig_miss_q <= 1'b0;
    else       trig_miss_q <= trig_miss_d;
  end

  assign bus.trig_miss = trig_miss_q;
`else
  assign trig_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    bnum_d  = bnum_q;
    ch_d    = ch_q;
    gate_d  = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        bnum_d = '0;
        if (bus.enable) begin
          if (trig_ok) start = 1'b1;
          else         state_d = StTrigWait;
        end
      end
      StBurst: begin
        cnt_d = cnt_q + 1'b1;
        if (!last_strobe) begin
          ch_d   = ch_q + 1'b1;
          gate_d = 1'b1;
        end else begin
          bnum_d  = (bnum_q == BnumPrimed) ? bnum_q : bnum_q + 2'd1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!period_end) cnt_d = cnt_q + 1'b1;
      end
      StTrigWait: begin
        if (!bus.enable)  state_d = StIdle;
        else if (trig_ok) start = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (period_end) begin
      if (!bus.enable)  state_d = StIdle;
      else if (trig_ok) start = 1'b1;
      else              state_d = StTrigWait;
    end

    // Period is latched only here, so mid-period changes wait for the next burst.
    if (start) begin
      state_d = StBurst;
      cnt_d   = '0;
      ch_d    = '0;
      per_d   = per_clamped;
      gate_d  = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      per_q   <= '0;
      bnum_q  <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      bnum_q  <= bnum_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      ch_q    <= ch_d;
    end
  end

  logic          primed_tag;
  logic          al_gate, al_primed;
  logic [Cw-1:0] al_ch;

  assign primed_tag = gate_q & (bnum_q >= BnumPrimed);

  diff_gate_sched_gate_align #(
    .Depth (DpLat),
    .ChW   (Cw)
  ) u_gate_align (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .gate_i   (gate_q),
    .ch_i     (ch_q),
    .primed_i (primed_tag),
    .gate_o   (al_gate),
    .ch_o     (al_ch),
    .primed_o (al_primed)
  );

  assign bus.gate       = gate_q;
  assign bus.ch_idx     = ch_q;
  assign bus.busy       = busy_q;
  assign bus.out_gate   = al_gate;
  assign bus.out_ch     = al_ch;
  assign bus.out_primed = al_primed;

endmodule

// File: doc/diff_gate_sched.md
Name: diff_gate_sched

Overview:
- Scheduler for the time-multiplexed double-difference datapath.
- Generates the per-channel gate strobe that drives the datapath's gate input: one burst of nch consecutive strobes per sample period, channel 0 first.
- Tracks the channel index and the datapath's 2-cycle gate latency, so downstream logic receives output channel and validity tags aligned to the datapath output.
- Flags which outputs carry a fully primed second difference after a start or restart.

Parameters:
- nch, 4, channels per burst; must equal the datapath history depth.
- pw, 12, width of the period register.
- cw, 2, channel index width; 2**cw >= nch.
- dp_lat, 2, datapath gate-to-output latency in cycles.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, run request; level sensitive.
- period, input, pw, burst-start spacing minus 1, in cycles.
- gate, output, 1, strobe to the datapath gate input.
- ch_idx, output, cw, channel index of the current gate strobe.
- busy, output, 1, high whenever the state is not IDLE.
- out_gate, output, 1, gate delayed dp_lat cycles; equals the expected datapath output valid.
- out_ch, output, cw, ch_idx delayed dp_lat cycles.
- out_primed, output, 1, high with out_gate when the output sample belongs to burst number >= 2 since leaving IDLE.
- trig, input, 1, present only when the optional feature is compiled in.
- trig_miss, output, 1, present only when the optional feature is compiled in.

Behaviour:
- Reset: synchronous and active-high, with clk and reset named as in the rest of the codebase. On reset:
  - state = IDLE;
  - gate, busy, out_gate, out_primed, trig_miss = 0;
  - ch_idx, out_ch = 0;
  - burst counter, period counter and alignment pipeline cleared.
- Reset mid-burst truncates the burst immediately; gate is 0 on the next cycle.
- States:
  - IDLE: enable sampled 1 at cycle t → per_r loaded, state = BURST, first gate at t+1.
  - BURST: gate = 1 for nch cycles, ch_idx = 0..nch-1, cnt counts 0..nch-1. After the last strobe:
    - if per_r == nch-1 and enable = 1, go directly to the next BURST (back-to-back);
    - otherwise go to WAIT.
  - WAIT: gate = 0 while cnt runs nch..per_r. At cnt == per_r:
    - enable = 1 → new BURST on the next cycle, per_r reloaded;
    - enable = 0 → IDLE.
- Burst starts are spaced exactly per_r+1 cycles apart.
- Period register:
  - per_r = max(period, nch-1), so bursts never overlap.
  - per_r is reloaded only at a burst start; period changes mid-burst or in WAIT take effect at the next burst.
- enable deasserted mid-burst: the burst always completes (all nch channels strobed), then the block finishes WAIT and goes to IDLE. No partial bursts, so channel alignment in the datapath is preserved.
- Burst counter:
  - bnum cleared on the IDLE→BURST transition; increments at each burst end and saturates at 2.
  - Output samples of bursts 0 and 1 carry stale difference history, so out_primed = 0 for them.
  - Re-entering IDLE clears priming.
- Alignment: out_gate, out_ch and the primed tag are a dp_lat-stage shift of (gate, ch_idx, bnum >= 2). When out_gate = 0, out_ch holds its last value and out_primed = 0.
- Counter width: cnt is pw bits; per_r = 2**pw - 1 is legal.

Optional Feature:
- Macro: DIFF_GATE_SCHED_TRIG_EN.
- Defined:
  - ports trig and trig_miss exist;
  - in WAIT at cnt == per_r the FSM holds in a TRIG_WAIT state until trig = 1 (or enable = 0 → IDLE), then starts a burst on the next cycle;
  - the first burst from IDLE also waits for trig;
  - a trig pulse in BURST or in WAIT before cnt == per_r sets sticky trig_miss, cleared only by reset;
  - trig and enable in the same cycle from IDLE: the burst starts at t+1.
- Undefined: free-running period timing only; trig and trig_miss absent.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE, BURST, WAIT, TRIG_WAIT;
  - DP_LAT = 2;
  - PRIME_BURSTS = 2.
- One sub-module: gate_align, a dp_lat-deep shift register carrying {gate, ch_idx, primed} with synchronous reset. It is reusable for other gated datapaths.

Test Plan:
- Reset, then enable = 1 at cycle 10 with nch = 4 and period = 9 → gate high at cycles 11-14, 21-24 and 31-34; ch_idx 0,1,2,3 in each burst; out_gate high at cycles 13-16.
- period = 1 (below nch-1) → clamped to 3; bursts back-to-back and gate continuously 1; ch_idx wraps 3→0 with no gap.
- Drop enable at the second strobe of a burst → remaining strobes ch 2 and 3 still issued; WAIT completes; busy falls after cnt == per_r.
- out_primed check → 0 for the first 8 out_gate pulses and 1 from the 9th onward; after enable toggles off and on it is 0 again for 8 pulses.
- Change period from 9 to 19 during a burst → the next spacing is still 10, the following spacing is 20.
- Assert reset during WAIT and mid-burst → all outputs 0 on the next cycle; out_gate stays 0 (pipeline cleared).
- With DIFF_GATE_SCHED_TRIG_EN defined:
  - trig at cycle 50 from TRIG_WAIT → gate at cycles 51-54;
  - trig at cycle 52 → trig_miss = 1 from cycle 53 and remains 1.
